// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state encoding and add/subtract mode constants for digit_serial_addsub.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational D-bit adder reporting carry-out and the carry into its MSB.
module digit_adder #(
  parameter int D = 1
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, cin};
  // the MSB sum bit is a^b^carry_in, so the carry into it falls out by re-XOR
  assign c_msb = sum[D-1] ^ a[D-1] ^ b[D-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: LSB-first digit-serial adder/subtractor, D bits per cycle over an N-bit word.
// Define ADDSUB_FLAGS_EN to compute ovf/zero/neg; otherwise those outputs are tied to 0.
module digit_serial_addsub import addsub_pkg::*; #(
  parameter int N = 4,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  localparam int ND = N / D;
  localparam int CW = $clog2(ND + 1);
  if (N < 1 || D < 1 || (N % D) != 0) begin : g_bad_width
    $error("digit_serial_addsub: N must be a positive multiple of D");
  end
  state_t       state;
  logic [N-1:0] a_sr, b_sr, res_sr, nxt_res;
  logic [CW-1:0] cnt;
  logic [D-1:0] sum;
  logic         carry, d_cout, c_msb, accept, last;
  digit_adder #(.D(D)) u_digit (
    .a(a_sr[D-1:0]),
    .b(b_sr[D-1:0]),
    .cin(carry),
    .sum(sum),
    .cout(d_cout),
`ifdef ADDSUB_FLAGS_EN
    .c_msb(c_msb)
`else
    .c_msb()
`endif
  );
  assign accept  = start && state != BUSY;
  assign last    = state == BUSY && cnt == CW'(ND - 1);
  // new digit enters at the top; after ND shifts the first digit sits at the LSB
  assign nxt_res = (res_sr >> D) | (N'(sum) << (N - D));
  assign busy    = state == BUSY;
  assign done    = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      state  <= BUSY;
      a_sr   <= a;
      b_sr   <= mode == MODE_SUB ? ~b : b;
      carry  <= cin;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      a_sr   <= a_sr >> D;
      b_sr   <= b_sr >> D;
      carry  <= d_cout;
      res_sr <= nxt_res;
      cnt    <= cnt + CW'(1);
      if (last) begin
        state  <= DONE;
        result <= nxt_res;
        cout   <= d_cout;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
`ifdef ADDSUB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (last) begin
      ovf  <= c_msb ^ d_cout;
      zero <= nxt_res == '0;
      neg  <= nxt_res[N-1];
    end
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
  assign neg  = 1'b0;
`endif
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: scoreboard bench for a 4-bit/1-bit and an 8-bit/2-bit digit_serial_addsub.
module tb_digit_serial_addsub;
  localparam int ND = 4;
  typedef struct {
    logic [7:0] res;
    logic       co, ov, z, ng;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start4 = 0, mode4 = 0, cin4 = 0, busy4, done4, cout4, ovf4, zero4, neg4;
  logic [3:0] a4 = 0, b4 = 0, result4;
  logic       start8 = 0, mode8 = 0, cin8 = 0, busy8, done8, cout8, ovf8, zero8, neg8;
  logic [7:0] a8 = 0, b8 = 0, result8;
  int         checks = 0, failures = 0, cyc = 0;
  exp_t       q4[$], q8[$];
  logic [7:0]  held4 = '0;
  logic [11:0] held8 = '0;

  digit_serial_addsub #(.N(4), .D(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4), .neg(neg4));
  digit_serial_addsub #(.N(8), .D(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8), .neg(neg8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  // reference: plain modulo-2^n arithmetic, signed overflow from operand/result signs
  function automatic exp_t model(int n, logic m, logic [7:0] x, logic [7:0] y, logic c);
    exp_t e;
    logic [7:0] mask, xe, ye;
    logic [8:0] full;
    mask  = 8'((9'd1 << n) - 9'd1);
    xe    = x & mask;
    ye    = (m ? ~y : y) & mask;
    full  = {1'b0, xe} + {1'b0, ye} + {8'b0, c};
    e.res = full[7:0] & mask;
    e.co  = full[n];
`ifdef ADDSUB_FLAGS_EN
    e.ov  = (xe[n-1] == ye[n-1]) && (e.res[n-1] != xe[n-1]);
    e.z   = e.res == 8'd0;
    e.ng  = e.res[n-1];
`else
    e.ov  = 1'b0;
    e.z   = 1'b0;
    e.ng  = 1'b0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) check("done4_spurious", {31'b0, done4}, 32'd0);
      else begin
        e = q4.pop_front();
        held4 = {e.res[3:0], e.co, e.ov, e.z, e.ng};
        check("res4", {result4, cout4, ovf4, zero4, neg4}, held4);
        check("lat4", cyc, e.cyc);
      end
    end else check("hold4", {result4, cout4, ovf4, zero4, neg4}, held4);
    if (done8) begin
      if (q8.size() == 0) check("done8_spurious", {31'b0, done8}, 32'd0);
      else begin
        e = q8.pop_front();
        held8 = {e.res, e.co, e.ov, e.z, e.ng};
        check("res8", {result8, cout8, ovf8, zero8, neg8}, held8);
        check("lat8", cyc, e.cyc);
      end
    end else check("hold8", {result8, cout8, ovf8, zero8, neg8}, held8);
  end

  // issue one operation; returns in the last BUSY cycle so a following op starts in DONE
  task automatic op(bit w8, logic m, logic [7:0] x, logic [7:0] y, logic c, bit poke);
    exp_t e;
    @(posedge clk); #1;
    e = model(w8 ? 8 : 4, m, x, y, c);
    e.cyc = cyc + ND + 1;
    if (w8) begin
      start8 = 1; mode8 = m; a8 = x; b8 = y; cin8 = c; q8.push_back(e);
    end else begin
      start4 = 1; mode4 = m; a4 = x[3:0]; b4 = y[3:0]; cin4 = c; q4.push_back(e);
    end
    for (int i = 0; i < ND; i++) begin
      @(posedge clk); #1;
      if (w8) begin
        start8 = poke && i == 1; mode8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        start4 = poke && i == 1; mode4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
    end
    if (w8) start8 = 0; else start4 = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset4", {busy4, done4, result4, cout4, ovf4, zero4, neg4}, 32'd0);
    check("reset8", {busy8, done8, result8, cout8, ovf8, zero8, neg8}, 32'd0);
    rst_n = 1;
    op(0, 1, 8'h8, 8'h8, 1, 0);
    op(0, 1, 8'h0, 8'hF, 1, 0);
    op(0, 1, 8'h9, 8'hB, 1, 0);
    op(0, 0, 8'h7, 8'h1, 0, 0);
    op(0, 0, 8'h5, 8'h6, 0, 1);
    op(1, 0, 8'hFF, 8'h01, 0, 0);
    op(1, 1, 8'h80, 8'h01, 1, 1);
    for (int i = 0; i < 40; i++) begin
      op(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 25; i++) begin
      op(1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    // abort an operation in its second BUSY cycle
    #1;
    start4 = 1; mode4 = 0; a4 = 4'h3; b4 = 4'h4; cin4 = 0;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #2;
    held4 = '0;
    held8 = '0;
    rst_n = 0;
    #1;
    check("abort4", {busy4, done4, result4, cout4, ovf4, zero4, neg4}, 32'd0);
    check("abort8", {busy8, done8, result8, cout8, ovf8, zero8, neg8}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) @(posedge clk);
    op(0, 1, 8'hC, 8'h3, 0, 0);
    op(1, 0, 8'h7F, 8'h01, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("drain4", q4.size(), 32'd0);
    check("drain8", q8.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
